// File: rtl/window_3x3_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a 3x3 shift window,
// qualified so that only neighbourhoods fully inside the image are flagged valid.
module window_3x3_gen #(
    parameter int WIDTH = 9,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_pixel,
    output logic             out_valid,
    output logic [WIDTH-1:0] w00,
    output logic [WIDTH-1:0] w01,
    output logic [WIDTH-1:0] w02,
    output logic [WIDTH-1:0] w10,
    output logic [WIDTH-1:0] w11,
    output logic [WIDTH-1:0] w12,
    output logic [WIDTH-1:0] w20,
    output logic [WIDTH-1:0] w21,
    output logic [WIDTH-1:0] w22,
    output logic             frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             col_last;
    logic             row_last;
    logic             win_inside;
    logic [WIDTH-1:0] lb0 [IMG_W];
    logic [WIDTH-1:0] lb1 [IMG_W];
    logic [WIDTH-1:0] lb0_rd;
    logic [WIDTH-1:0] lb1_rd;

    assign col_last   = (col == CW'(IMG_W - 1));
    assign row_last   = (row == RW'(IMG_H - 1));
    assign win_inside = (row >= RW'(2)) && (col >= CW'(2));
    assign lb0_rd     = lb0[col];
    assign lb1_rd     = lb1[col];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffers are not reset; out_valid gating keeps stale contents hidden.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb0[col] <= lb1_rd;
            lb1[col] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w00 <= '0; w01 <= '0; w02 <= '0;
            w10 <= '0; w11 <= '0; w12 <= '0;
            w20 <= '0; w21 <= '0; w22 <= '0;
        end else if (in_valid) begin
            w00 <= w01; w01 <= w02; w02 <= lb0_rd;
            w10 <= w11; w11 <= w12; w12 <= lb1_rd;
            w20 <= w21; w21 <= w22; w22 <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= in_valid && win_inside;
            frame_done <= in_valid && row_last && col_last;
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen: a pixel-history model checks two differently sized
// instances every cycle, with literal window values pinning the directed scenarios.
module tb_window_3x3_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [8:0] in_pixel = '0;

    logic       v0, v1, d0, d1;
    logic [8:0] w0 [9];
    logic [8:0] w1 [9];

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    window_3x3_gen #(.WIDTH(9), .IMG_W(4), .IMG_H(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pixel(in_pixel),
        .out_valid(v0),
        .w00(w0[0]), .w01(w0[1]), .w02(w0[2]),
        .w10(w0[3]), .w11(w0[4]), .w12(w0[5]),
        .w20(w0[6]), .w21(w0[7]), .w22(w0[8]),
        .frame_done(d0));

    window_3x3_gen #(.WIDTH(9), .IMG_W(5), .IMG_H(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pixel(in_pixel),
        .out_valid(v1),
        .w00(w1[0]), .w01(w1[1]), .w02(w1[2]),
        .w10(w1[3]), .w11(w1[4]), .w12(w1[5]),
        .w20(w1[6]), .w21(w1[7]), .w22(w1[8]),
        .frame_done(d1));

    // Model state per instance: history of accepted pixels and the resulting expectations.
    int   hist0[$];
    int   hist1[$];
    int   acc [2];
    bit   known [2];
    bit   ev [2];
    bit   ed [2];
    int   ew [2][9];

    // Windows seen on dut0 (row-major, 9 values each) and its frame_done count.
    int   cap[$];
    int   done_cnt = 0;

    function automatic int img_w(int d); return (d == 0) ? 4 : 5; endfunction
    function automatic int img_h(int d); return (d == 0) ? 4 : 3; endfunction

    function automatic int dut_w(int d, int k);
        return (d == 0) ? int'(w0[k]) : int'(w1[k]);
    endfunction

    task automatic check(string nm, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        hist0.delete();
        hist1.delete();
        for (int d = 0; d < 2; d++) begin
            acc[d] = 0; known[d] = 1'b1; ev[d] = 1'b0; ed[d] = 1'b0;
            for (int k = 0; k < 9; k++) ew[d][k] = 0;
        end
    endtask

    // Window element (row x, column y) after an accept is the pixel accepted
    // (2-y) + (2-x)*IMG_W accepts earlier, independent of frame boundaries.
    task automatic model_accept(int d, int pix);
        int w, h, r, c, n, depth;
        w = img_w(d); h = img_h(d);
        r = acc[d] / w; c = acc[d] % w;
        ev[d] = (r >= 2) && (c >= 2);
        ed[d] = (r == h - 1) && (c == w - 1);
        depth = 2 * w + 3;
        if (d == 0) begin
            hist0.push_back(pix);
            if (hist0.size() > depth) void'(hist0.pop_front());
            n = hist0.size();
        end else begin
            hist1.push_back(pix);
            if (hist1.size() > depth) void'(hist1.pop_front());
            n = hist1.size();
        end
        known[d] = (n == depth);
        if (known[d]) begin
            for (int x = 0; x < 3; x++)
                for (int y = 0; y < 3; y++)
                    ew[d][3*x+y] = (d == 0) ? hist0[n-1-(2-y)-(2-x)*w]
                                            : hist1[n-1-(2-y)-(2-x)*w];
        end
        acc[d] = (acc[d] + 1) % (w * h);
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d out_valid", d), int'((d == 0) ? v0 : v1), int'(ev[d]));
            check($sformatf("d%0d frame_done", d), int'((d == 0) ? d0 : d1), int'(ed[d]));
            if (known[d])
                for (int k = 0; k < 9; k++)
                    check($sformatf("d%0d w%0d%0d", d, k / 3, k % 3), dut_w(d, k), ew[d][k]);
        end
    endtask

    // Compare/model process: outputs are checked mid-cycle, then the inputs that the
    // next rising edge will accept are folded into the model.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            compare_all();
            if (rst_n) begin
                if (v0) begin
                    for (int k = 0; k < 9; k++) cap.push_back(int'(w0[k]));
                    if (d0) done_cnt++;
                end
                for (int d = 0; d < 2; d++) begin
                    if (in_valid) model_accept(d, int'(in_pixel));
                    else begin ev[d] = 1'b0; ed[d] = 1'b0; end
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(int pix, int gap);
        in_valid = 1'b1;
        in_pixel = 9'(pix);
        tick(1);
        in_valid = 1'b0;
        tick(gap);
    endtask

    task automatic clear_cap();
        cap.delete();
        done_cnt = 0;
    endtask

    task automatic check_win(string nm, int idx, int e[9]);
        if (cap.size() < 9 * (idx + 1)) begin
            compared++; mismatched++;
            $display("FAIL %s: window %0d missing, only %0d captured", nm, idx, cap.size() / 9);
        end else begin
            for (int k = 0; k < 9; k++)
                check($sformatf("%s w%0d%0d", nm, k / 3, k % 3), cap[9*idx+k], e[k]);
        end
    endtask

    task automatic check_frame_4x4(string nm);
        check({nm, " window count"}, cap.size() / 9, 4);
        check({nm, " frame_done count"}, done_cnt, 1);
        check_win({nm, " first"}, 0, '{0, 1, 2, 4, 5, 6, 8, 9, 10});
        check_win({nm, " last"}, 3, '{5, 6, 7, 9, 10, 11, 13, 14, 15});
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(1);

        clear_cap();
        for (int i = 0; i < 16; i++) send(i, 0);
        tick(2);
        check_frame_4x4("continuous");

        clear_cap();
        for (int i = 0; i < 16; i++) send(i, 3);
        tick(2);
        check_frame_4x4("gapped");

        clear_cap();
        for (int i = 0; i < 16; i++) send(i, 0);
        for (int i = 0; i < 16; i++) send(100 + i, 0);
        tick(2);
        check({"two frames", " window count"}, cap.size() / 9, 8);
        check({"two frames", " frame_done count"}, done_cnt, 2);
        check_win("frame2 first", 4, '{100, 101, 102, 104, 105, 106, 108, 109, 110});
        check_win("frame2 last", 7, '{105, 106, 107, 109, 110, 111, 113, 114, 115});

        for (int i = 0; i < 8; i++) send(i, 0);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        clear_cap();
        for (int i = 0; i < 16; i++) send(i, 0);
        tick(2);
        check_frame_4x4("after reset");

        clear_cap();
        for (int i = 0; i < 16; i++) send((i == 5) ? 0 : 511, 0);
        tick(2);
        check_win("full scale", 0, '{511, 511, 511, 511, 0, 511, 511, 511, 511});

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                in_valid = 1'b0;
                rst_n = 1'b0;
                tick($urandom_range(1, 2));
                rst_n = 1'b1;
            end
            in_valid = ($urandom_range(0, 9) < 7);
            in_pixel = 9'($urandom);
            tick(1);
        end
        in_valid = 1'b0;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Sliding-window generator placed directly upstream of the 3x3 convolution unit.
- Accepts a raster-order pixel stream (row-major, one pixel per accepted cycle) and buffers two full lines internally.
- Presents the nine pixels of each complete 3x3 neighbourhood on w00..w22, which drive the convolution unit's activation inputs a00..a22.
- out_valid marks each cycle where the window is a legal, fully-inside-image neighbourhood.

Parameters:
WIDTH, 9, pixel bit width (matches convolution unit WIDTH)
IMG_W, 28, pixels per line, must be >= 3
IMG_H, 28, lines per frame, must be >= 3

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_pixel is accepted on this rising edge
in_pixel  input  WIDTH  incoming pixel, raster order
out_valid  output  1  window outputs hold a valid 3x3 neighbourhood this cycle
w00,w01,w02  output  WIDTH each  top row (line r-2), columns c-2, c-1, c
w10,w11,w12  output  WIDTH each  middle row (line r-1), columns c-2, c-1, c
w20,w21,w22  output  WIDTH each  bottom row (line r), columns c-2, c-1, c
frame_done  output  1  one-cycle pulse coincident with the last valid window of a frame

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-low (rst_n).
  - While rst_n is low, all outputs are 0: out_valid, frame_done, w00..w22.
  - col and row counters are cleared to 0.
  - Line-buffer contents need not be cleared. Stale data is never exposed because out_valid stays low until row>=2 and col>=2 of the new frame.
- Counters:
  - col runs 0..IMG_W-1; row runs 0..IMG_H-1.
  - Both advance only on accept (in_valid=1).
  - col wraps to 0 and row increments at col=IMG_W-1.
  - At row=IMG_H-1 and col=IMG_W-1, both wrap to 0 and the next frame starts immediately.
- Line buffers: two IMG_W-deep delay lines, lb1 (line r-1) and lb0 (line r-2).
  - On accept at column col: lb0[col] <= lb1[col] and lb1[col] <= in_pixel.
  - Read data is the pre-update value at the same col.
  - Register-array or RAM-style implementation is allowed, but it must provide same-cycle read-before-write.
- Window shift on accept, with all columns moving left:
  - wX0 <= wX1, wX1 <= wX2.
  - w02 <= lb0[col] (old value), w12 <= lb1[col] (old value), w22 <= in_pixel.
- Window hold: with no accept, w00..w22 hold their values.
- out_valid:
  - Registered; asserted the cycle after an accept where the accepted pixel's coordinates satisfy row>=2 and col>=2.
  - Otherwise 0.
  - Latency is 1 clock from accept to window output.
  - Exactly one out_valid pulse per qualifying accept. It is low during in_valid gaps, even though the window is held.
- Row-wrap contamination: windows at col 0..1 mix pixels from the previous line's tail. These windows are suppressed by the col>=2 rule.
- frame_done: registered, asserted together with out_valid for the accept at row=IMG_H-1, col=IMG_W-1.
- Valid-window count: (IMG_W-2)*(IMG_H-2) per frame.
- Data path: no arithmetic; pixels pass bit-exact, with no sign or width change.
- Back-pressure: none. The downstream convolution unit must consume every out_valid cycle.
- Reset mid-frame: counters return to 0 and out_valid/frame_done drop asynchronously. The first valid window of the restarted frame appears one cycle after the pixel at row 2, col 2 is accepted.

Test Plan:
- IMG_W=4, IMG_H=4, continuous in_valid, pixel = 4*row+col (0..15):
  - first out_valid one cycle after accepting pixel 10, with w00..w22 = 0,1,2,4,5,6,8,9,10.
  - exactly 4 valid windows total, the last being 5,6,7,9,10,11,13,14,15, with frame_done high on that cycle only.
- Same stream with in_valid deasserted for 3 cycles after every pixel:
  - identical window sequence and count.
  - out_valid is never high during gaps.
  - window outputs hold constant across gaps.
- Two back-to-back frames (second frame pixel = 100+index):
  - second frame's first window is 100,101,102,104,105,106,108,109,110.
  - no valid window straddles the frame boundary.
  - frame_done fires twice.
- Assert rst_n low for 2 cycles after pixel 7 of a frame, then restart the stream at pixel 0:
  - all outputs read 0 during reset.
  - the restarted frame produces exactly 4 valid windows matching the first scenario.
- WIDTH=9, all pixels 9'h1FF except the centre pixel (row 1, col 1) = 9'h000:
  - the first window shows w11=0 and all other outputs = 9'h1FF, with no truncation.
